// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes engine: LANES forward/inverse S-box lanes walk the
// 16 bytes of a 128-bit state in BEATS = 16/LANES cycles behind a valid/ready pair.

// GF(2^8) multiplicative inverse (0 maps to 0), shared by both S-box directions.
module gf_inv8 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 = a^-1: multiply together a^2, a^4, ..., a^128.
  always_comb begin
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    y = r;
  end
endmodule

module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] v;

  gf_inv8 u_inv (.a(a), .y(v));

  assign y = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
             {v[3:0], v[7:4]} ^ 8'h63;
endmodule

module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] u;

  // Inverse affine map, then field inverse.
  assign u = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

  gf_inv8 u_inv (.a(u), .y(y));
endmodule

// Handshake: a transfer happens on a rising edge where valid & ready are both 1;
// valid never drops without its transfer, and data is held stable while valid & !ready.
module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [1:0]   dbg_state
);
  localparam int BEATS = 16 / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [127:0]    st;
  logic [127:0]    st_nxt;
  logic            inv_q;
  logic [BW-1:0]   beat;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      fwd_out  [LANES];
  logic [7:0]      inv_out  [LANES];

  // Bytes beat*LANES .. beat*LANES+LANES-1, byte 0 at the MSB end.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = st[127 - 8 * (int'(beat) * LANES + l) -: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sbox     u_fwd (.a(lane_in[l]), .y(fwd_out[l]));
    inv_sbox u_inv (.a(lane_in[l]), .y(inv_out[l]));
  end

  always_comb begin
    st_nxt = st;
    for (int l = 0; l < LANES; l++) begin
      st_nxt[127 - 8 * (int'(beat) * LANES + l) -: 8] = inv_q ? inv_out[l] : fwd_out[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      st        <= '0;
      inv_q     <= 1'b0;
      beat      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= in_data;
            inv_q <= in_inv;
            beat  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          st <= st_nxt;
          if (beat == BW'(BEATS - 1)) begin
            beat      <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              st    <= in_data;
              inv_q <= in_inv;
              beat  <= '0;
              state <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_data  = st;
  assign dbg_state = state;
endmodule
